// File: rtl/seq_chunk_adder_pkg.sv
// Shared types and sizing helpers for the chunked sequential adder.
// Optional feature macro: SEQ_CHUNK_ADDER_OVF_EN (signed overflow flag).
package seq_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int calc_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-chunk configuration still needs a 1-bit index register.
    function automatic int calc_idx_w(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/seq_chunk_adder_if.sv
// Start/busy/done handshake and operand/result bus for seq_chunk_adder.
// The ovf signal exists only when SEQ_CHUNK_ADDER_OVF_EN is defined.
interface seq_chunk_adder_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    logic             ovf;
`endif

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
`ifdef SEQ_CHUNK_ADDER_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
`ifdef SEQ_CHUNK_ADDER_OVF_EN
        , output ovf
`endif
    );

endinterface

// File: rtl/seq_chunk_adder_chunk_add.sv
// Combinational CHUNK-bit ripple adder built from one-bit full-adder cells.
// Also exposes the carry into the MSB cell for signed-overflow detection.
module chunk_add #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [CHUNK:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co    = c[CHUNK];
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder: WIDTH-bit a+b+cin, CHUNK bits per clock, LSB chunk first.
// Define SEQ_CHUNK_ADDER_OVF_EN to add the two's-complement overflow output.
module seq_chunk_adder
    import seq_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input logic              clk,
    input logic              rst,
    seq_chunk_adder_if.slave bus
);

    localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int IDX_W  = calc_idx_w(NCHUNK);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] sum_r;
    logic             carry_r;
    logic             cout_r;
    logic [IDX_W-1:0] idx_r;

    logic             accept;
    logic             last;
    logic [CHUNK-1:0] s_chunk;
    logic             co_chunk;

    // Start is only honoured when no operation is in flight.
    assign accept = bus.start && (state_q == IDLE || state_q == DONE);
    assign last   = (state_q == RUN) && (idx_r == IDX_W'(NCHUNK - 1));

`ifdef SEQ_CHUNK_ADDER_OVF_EN
    logic msb_ci;
    logic ovf_r;
`else
    logic msb_ci_unused;
`endif

    chunk_add #(.CHUNK(CHUNK)) u_chunk_add (
        .a     (a_r[idx_r*CHUNK +: CHUNK]),
        .b     (b_r[idx_r*CHUNK +: CHUNK]),
        .ci    (carry_r),
        .s     (s_chunk),
        .co    (co_chunk),
`ifdef SEQ_CHUNK_ADDER_OVF_EN
        .c_msb (msb_ci)
`else
        .c_msb (msb_ci_unused)
`endif
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (last)   state_d = DONE;
            DONE:    state_d = accept ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
            idx_r   <= '0;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
            ovf_r   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_r     <= bus.a;
                b_r     <= bus.b;
                carry_r <= bus.cin;
                idx_r   <= '0;
                sum_r   <= '0;
                cout_r  <= 1'b0;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
                ovf_r   <= 1'b0;
`endif
            end else if (state_q == RUN) begin
                // One chunk per edge; the carry register links the chunks.
                sum_r[idx_r*CHUNK +: CHUNK] <= s_chunk;
                carry_r <= co_chunk;
                idx_r   <= idx_r + 1'b1;
                if (last) begin
                    cout_r <= co_chunk;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
                    ovf_r  <= msb_ci ^ co_chunk;
`endif
                end
            end
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    assign bus.ovf  = ovf_r;
`endif

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed self-checking bench for seq_chunk_adder (WIDTH=16, CHUNK=4).
// Overflow checks are compiled in when SEQ_CHUNK_ADDER_OVF_EN is defined.
module tb_seq_chunk_adder;

    localparam int WIDTH  = 16;
    localparam int CHUNK  = 4;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    seq_chunk_adder_if #(.WIDTH(WIDTH)) bus ();

    seq_chunk_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic [WIDTH-1:0] av,
                         input logic [WIDTH-1:0] bv, input logic ci);
        bus.start = st;
        bus.a     = av;
        bus.b     = bv;
        bus.cin   = ci;
    endtask

    task automatic run_op(input string tag, input logic [WIDTH-1:0] av,
                          input logic [WIDTH-1:0] bv, input logic ci,
                          input logic [WIDTH-1:0] exp_sum, input logic exp_cout,
                          input logic exp_ovf);
        drive(1'b1, av, bv, ci);
        tick();
        drive(1'b0, 16'hDEAD, 16'hBEEF, 1'b1);
        for (int c = 1; c <= NCHUNK; c++) begin
            chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
            chk({tag, "_nodone"}, 32'(bus.done), 32'd0);
            tick();
        end
        chk({tag, "_done"}, 32'(bus.done), 32'd1);
        chk({tag, "_busy_low"}, 32'(bus.busy), 32'd0);
        chk({tag, "_sum"}, 32'(bus.sum), 32'(exp_sum));
        chk({tag, "_cout"}, 32'(bus.cout), 32'(exp_cout));
`ifdef SEQ_CHUNK_ADDER_OVF_EN
        chk({tag, "_ovf"}, 32'(bus.ovf), 32'(exp_ovf));
`else
        if (exp_ovf === 1'bx) $display("unexpected X in expected ovf for %s", tag);
`endif
        tick();
        chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        chk({tag, "_sum_held"}, 32'(bus.sum), 32'(exp_sum));
        chk({tag, "_cout_held"}, 32'(bus.cout), 32'(exp_cout));
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst   = 1'b1;
        drive(1'b0, '0, '0, 1'b0);
        tick();
        tick();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_sum", 32'(bus.sum), 32'd0);
        chk("rst_cout", 32'(bus.cout), 32'd0);
`ifdef SEQ_CHUNK_ADDER_OVF_EN
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
`endif
        rst = 1'b0;
        tick();
        chk("idle_busy", 32'(bus.busy), 32'd0);

        run_op("carry_across", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
        run_op("wrap",         16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("cin_only",     16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
        run_op("signed_ovf",   16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);

        // Start re-pulsed while busy must be ignored.
        drive(1'b1, 16'h1234, 16'h1111, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0);
        tick();
        drive(1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
        tick();
        drive(1'b0, '0, '0, 1'b0);
        chk("ign_busy3", 32'(bus.busy), 32'd1);
        tick();
        tick();
        chk("ign_done", 32'(bus.done), 32'd1);
        chk("ign_sum", 32'(bus.sum), 32'h2345);
        chk("ign_cout", 32'(bus.cout), 32'd0);
        tick();
        chk("ign_no_restart", 32'(bus.busy), 32'd0);
        chk("ign_done_low", 32'(bus.done), 32'd0);

        // Start held high: back-to-back ops, done every NCHUNK+1 cycles.
        drive(1'b1, 16'h0F0F, 16'h0101, 1'b0);
        for (int c = 1; c <= 3 * (NCHUNK + 1); c++) begin
            tick();
            if (c % (NCHUNK + 1) == 0) begin
                chk("b2b_done", 32'(bus.done), 32'd1);
                chk("b2b_sum", 32'(bus.sum), 32'h1010);
                chk("b2b_cout", 32'(bus.cout), 32'd0);
            end else begin
                chk("b2b_busy", 32'(bus.busy), 32'd1);
                chk("b2b_nodone", 32'(bus.done), 32'd0);
            end
        end
        drive(1'b0, '0, '0, 1'b0);
        tick();
        chk("b2b_idle", 32'(bus.busy), 32'd0);

        // Reset in cycle 3 of an op aborts it with no done pulse.
        drive(1'b1, 16'h00FF, 16'h0001, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_sum", 32'(bus.sum), 32'd0);
        chk("abort_cout", 32'(bus.cout), 32'd0);
        for (int c = 0; c < 2 * (NCHUNK + 1); c++) begin
            tick();
            chk("abort_no_done", 32'(bus.done), 32'd0);
        end
        run_op("after_abort", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    // Hard stop if the stimulus sequence itself stalls.
    initial begin
        #50000;
        $display("FAIL timeout: got no finish expected finish within 50000");
        $fatal(1, "timeout");
    end

endmodule
